// File: rtl/if_fetch_queue.sv
// Pipelined instruction-fetch front end: issues up to MAX_OUTSTANDING
// inst SRAM requests, buffers responses in a FIFO, flushes on redirect.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        fs_to_ds_adel,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int QW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pcq [MAX_OUTSTANDING];
  logic [PW-1:0] r_pcq_wr;
  logic [PW-1:0] r_pcq_rd;
  logic [OW-1:0] r_outst;
  logic [OW-1:0] r_discard;
  logic [31:0]   r_q_pc   [QUEUE_DEPTH];
  logic [31:0]   r_q_inst [QUEUE_DEPTH];
  logic          r_q_adel [QUEUE_DEPTH];
  logic [QW-1:0] r_q_wr;
  logic [QW-1:0] r_q_rd;
  logic [CW-1:0] r_count;
  logic          r_halt;

  logic          w_misalign;
  logic [31:0]   w_used;
  logic          w_credit;
  logic          w_slot;
  logic          w_req;
  logic          w_issue;
  logic          w_resp;
  logic          w_live;
  logic          w_adel_push;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;
  logic [31:0]   w_push_pc;
  logic [31:0]   w_push_inst;
  logic [PW-1:0] w_pcq_wr_nx;
  logic [PW-1:0] w_pcq_rd_nx;

  // stale requests still hold an outstanding slot but never a queue slot
  assign w_misalign  = r_fetch_pc[1:0] != 2'b00;
  assign w_used      = 32'(r_count) + 32'(r_outst) - 32'(r_discard);
  assign w_credit    = w_used < 32'(QUEUE_DEPTH);
  assign w_slot      = 32'(r_outst) < 32'(MAX_OUTSTANDING);
  assign w_req       = ~reset & ~redirect_valid & ~r_halt &
                       ~w_misalign & w_slot & w_credit;
  assign w_issue     = w_req & inst_sram_addr_ok;
  assign w_resp      = inst_sram_data_ok;
  assign w_live      = w_resp & (r_discard == '0) & ~redirect_valid;
  assign w_adel_push = w_misalign & ~r_halt & (r_outst == '0) &
                       (32'(r_count) < 32'(QUEUE_DEPTH)) &
                       ~redirect_valid & ~reset;
  assign w_push      = w_live | w_adel_push;
  assign w_valid     = (r_count != '0) & ~redirect_valid;
  assign w_pop       = w_valid & ds_allowin;
  assign w_push_pc   = w_adel_push ? r_fetch_pc : r_pcq[r_pcq_rd];
  assign w_push_inst = w_adel_push ? 32'h0 : inst_sram_rdata;

  assign w_pcq_wr_nx = (r_pcq_wr == PW'(MAX_OUTSTANDING - 1)) ?
                       '0 : r_pcq_wr + PW'(1);
  assign w_pcq_rd_nx = (r_pcq_rd == PW'(MAX_OUTSTANDING - 1)) ?
                       '0 : r_pcq_rd + PW'(1);

  assign fs_to_ds_valid  = w_valid;
  assign fs_to_ds_pc     = r_q_pc[r_q_rd];
  assign fs_to_ds_inst   = r_q_inst[r_q_rd];
  assign fs_to_ds_adel   = r_q_adel[r_q_rd];

  assign inst_sram_req   = w_req;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'h2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_addr  = r_fetch_pc;
  assign inst_sram_wdata = 32'h0;

  // fetch PC, halt flag and the in-flight bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_halt     <= 1'b0;
      r_outst    <= '0;
      r_discard  <= '0;
      r_pcq_wr   <= '0;
      r_pcq_rd   <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_pcq[i] <= '0;
    end else begin
      r_outst <= r_outst + OW'(w_issue) - OW'(w_resp);
      if (w_issue) begin
        r_pcq[r_pcq_wr] <= r_fetch_pc;
        r_pcq_wr        <= w_pcq_wr_nx;
      end
      if (w_resp) r_pcq_rd <= w_pcq_rd_nx;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_halt     <= 1'b0;
        r_discard  <= r_outst - OW'(w_resp);
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_adel_push) r_halt <= 1'b1;
        if (w_resp && r_discard != '0) r_discard <= r_discard - OW'(1);
      end
    end
  end

  // instruction queue: single-cycle flush on redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_q_wr  <= '0;
      r_q_rd  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_pc[i]   <= '0;
        r_q_inst[i] <= '0;
        r_q_adel[i] <= 1'b0;
      end
    end else if (redirect_valid) begin
      r_count <= '0;
      r_q_wr  <= '0;
      r_q_rd  <= '0;
    end else begin
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        r_q_pc[r_q_wr]   <= w_push_pc;
        r_q_inst[r_q_wr] <= w_push_inst;
        r_q_adel[r_q_wr] <= w_adel_push;
        r_q_wr           <= r_q_wr + QW'(1);
      end
      if (w_pop) r_q_rd <= r_q_rd + QW'(1);
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order SRAM model
// and a decode-side log of every delivered entry.
module tb_if_fetch_queue;

  localparam logic [31:0] B = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rv = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        allow = 1'b1;
  logic        addr_ok = 1'b1;
  logic        rsp_en = 1'b1;
  logic        data_ok;
  logic [31:0] rdata;

  logic        valid, adel, req, wr;
  logic [31:0] pc, inst, addr, wdata;
  logic [1:0]  size;
  logic [3:0]  wstrb;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk(clk), .reset(reset),
    .redirect_valid(rv), .redirect_pc(rpc),
    .ds_allowin(allow),
    .fs_to_ds_valid(valid), .fs_to_ds_pc(pc),
    .fs_to_ds_inst(inst), .fs_to_ds_adel(adel),
    .inst_sram_req(req), .inst_sram_wr(wr),
    .inst_sram_size(size), .inst_sram_wstrb(wstrb),
    .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_addr_ok(addr_ok),
    .inst_sram_data_ok(data_ok),
    .inst_sram_rdata(rdata)
  );

  // in-order SRAM model; data is the bitwise inverse of the address
  logic [31:0] m_addr [16];
  int m_wr = 0, m_rd = 0, m_cnt = 0;
  always_comb begin
    data_ok = rsp_en && (m_cnt > 0);
    rdata = data_ok ? ~m_addr[m_rd[3:0]] : 32'h0;
  end
  always @(posedge clk) begin
    if (reset) begin
      m_wr <= 0; m_rd <= 0; m_cnt <= 0;
    end else begin
      if (req && addr_ok) begin
        m_addr[m_wr[3:0]] <= addr;
        m_wr <= (m_wr + 1) % 16;
      end
      if (data_ok) m_rd <= (m_rd + 1) % 16;
      m_cnt <= m_cnt + ((req && addr_ok) ? 1 : 0) - (data_ok ? 1 : 0);
    end
  end

  // decode-side log of accepted entries
  logic [31:0] lpc [512];
  logic [31:0] linst [512];
  logic        ladel [512];
  int n_log = 0;
  always @(posedge clk) begin
    if (!reset && valid && allow && n_log < 512) begin
      lpc[n_log]   <= pc;
      linst[n_log] <= inst;
      ladel[n_log] <= adel;
      n_log <= n_log + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; rv = 1'b0;
    tick();
    tick();
    chk("req_in_reset", {31'b0, req}, 32'd0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        allow;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vec [22];
  int mark;
  int cnt;

  initial begin
    vec[0]  = '{1'b1, 1'b1, B + 32'h00, 1'b0, B + 32'h00};
    vec[1]  = '{1'b1, 1'b1, B + 32'h04, 1'b0, B + 32'h00};
    vec[2]  = '{1'b1, 1'b1, B + 32'h08, 1'b1, B + 32'h00};
    vec[3]  = '{1'b1, 1'b1, B + 32'h0c, 1'b1, B + 32'h04};
    vec[4]  = '{1'b1, 1'b1, B + 32'h10, 1'b1, B + 32'h08};
    vec[5]  = '{1'b1, 1'b1, B + 32'h14, 1'b1, B + 32'h0c};
    vec[6]  = '{1'b0, 1'b1, B + 32'h18, 1'b1, B + 32'h10};
    vec[7]  = '{1'b0, 1'b1, B + 32'h1c, 1'b1, B + 32'h10};
    vec[8]  = '{1'b0, 1'b0, B + 32'h20, 1'b1, B + 32'h10};
    for (int k = 9; k <= 15; k++)
      vec[k] = '{1'b0, 1'b0, B + 32'h20, 1'b1, B + 32'h10};
    vec[16] = '{1'b1, 1'b0, B + 32'h20, 1'b1, B + 32'h10};
    vec[17] = '{1'b1, 1'b1, B + 32'h20, 1'b1, B + 32'h14};
    vec[18] = '{1'b1, 1'b1, B + 32'h24, 1'b1, B + 32'h18};
    vec[19] = '{1'b1, 1'b1, B + 32'h28, 1'b1, B + 32'h1c};
    vec[20] = '{1'b1, 1'b1, B + 32'h2c, 1'b1, B + 32'h20};
    vec[21] = '{1'b1, 1'b1, B + 32'h30, 1'b1, B + 32'h24};

    // reset release, streaming, then decode stall and resume
    do_reset();
    chk("const_size", {30'b0, size}, 32'h2);
    chk("const_wr", {31'b0, wr}, 32'h0);
    for (int k = 0; k < 22; k++) begin
      if (k > 0) tick();
      allow = vec[k].allow;
      #1;
      chk($sformatf("row%0d req", k), {31'b0, req}, {31'b0, vec[k].req});
      chk($sformatf("row%0d addr", k), addr, vec[k].addr);
      chk($sformatf("row%0d valid", k), {31'b0, valid},
          {31'b0, vec[k].valid});
      if (vec[k].valid) begin
        chk($sformatf("row%0d pc", k), pc, vec[k].pc);
        chk($sformatf("row%0d inst", k), inst, ~vec[k].pc);
      end
      if (k == 9) chk("full_count", 32'(dut.r_count), 32'd4);
    end

    // two requests in flight when redirected; both must be dropped
    do_reset();
    addr_ok = 1'b0; rsp_en = 1'b0; rv = 1'b1; rpc = 32'h100; allow = 1'b1;
    #1 chk("s2_c0_req", {31'b0, req}, 32'd0);
    mark = n_log;
    tick(); rv = 1'b0; addr_ok = 1'b1;
    #1 chk("s2_c1_addr", addr, 32'h100);
    tick();
    #1 chk("s2_c2_addr", addr, 32'h104);
    tick(); rv = 1'b1; rpc = 32'h200;
    #1 chk("s2_c3_req", {31'b0, req}, 32'd0);
    tick(); rv = 1'b0; rsp_en = 1'b1;
    #1 chk("s2_c4_req", {31'b0, req}, 32'd0);
    chk("s2_c4_valid", {31'b0, valid}, 32'd0);
    tick();
    #1 chk("s2_c5_req", {31'b0, req}, 32'd1);
    chk("s2_c5_addr", addr, 32'h200);
    repeat (6) tick();
    chk("s2_first_pc", lpc[mark], 32'h200);
    chk("s2_first_inst", linst[mark], ~32'h200);
    chk("s2_second_pc", lpc[mark + 1], 32'h204);

    // redirect together with data_ok while two are outstanding
    tick(); rsp_en = 1'b0;
    tick(); rsp_en = 1'b1; rv = 1'b1; rpc = 32'h300;
    #1 chk("s3_valid_redir", {31'b0, valid}, 32'd0);
    tick(); rv = 1'b0;
    #1 chk("s3_valid", {31'b0, valid}, 32'd0);
    chk("s3_count", 32'(dut.r_count), 32'd0);
    chk("s3_outst", 32'(dut.r_outst), 32'd1);
    chk("s3_discard", 32'(dut.r_discard), 32'd1);
    mark = n_log;
    repeat (8) tick();
    chk("s3_first_pc", lpc[mark], 32'h300);
    chk("s3_second_pc", lpc[mark + 1], 32'h304);
    cnt = 0;
    for (int i = mark; i < n_log; i++)
      if (lpc[i][31:8] != 24'h3 || linst[i] != ~lpc[i]) cnt++;
    chk("s3_stale_entries", 32'(cnt), 32'd0);

    // misaligned redirect target: one AdEL entry, then silence
    tick(); rv = 1'b1; rpc = 32'h202;
    tick(); rv = 1'b0;
    mark = n_log;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1 if (req) cnt++;
      tick();
    end
    chk("s4_req_cycles", 32'(cnt), 32'd0);
    chk("s4_entries", 32'(n_log - mark), 32'd1);
    chk("s4_pc", lpc[mark], 32'h202);
    chk("s4_inst", linst[mark], 32'h0);
    chk("s4_adel", {31'b0, ladel[mark]}, 32'd1);

    // reset with two outstanding and two queued entries
    rv = 1'b1; rpc = 32'h500; allow = 1'b0; rsp_en = 1'b1;
    tick(); rv = 1'b0;
    tick();
    tick();
    tick(); rsp_en = 1'b0;
    tick();
    #1 chk("s5_pre_count", 32'(dut.r_count), 32'd2);
    chk("s5_pre_outst", 32'(dut.r_outst), 32'd2);
    reset = 1'b1;
    tick();
    #1 chk("s5_valid", {31'b0, valid}, 32'd0);
    chk("s5_req", {31'b0, req}, 32'd0);
    chk("s5_count", 32'(dut.r_count), 32'd0);
    chk("s5_outst", 32'(dut.r_outst), 32'd0);
    chk("s5_discard", 32'(dut.r_discard), 32'd0);
    chk("s5_halt", {31'b0, dut.r_halt}, 32'd0);
    reset = 1'b0; allow = 1'b1; rsp_en = 1'b1;
    #1 chk("s5_restart_req", {31'b0, req}, 32'd1);
    chk("s5_restart_addr", addr, B);
    mark = n_log;
    repeat (5) tick();
    chk("s5_first_pc", lpc[mark], B);
    chk("s5_second_pc", lpc[mark + 1], B + 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
